// File: rtl/fp_to_int_share_arbiter.sv
// Round-robin sharing of one fixed-latency FP32->Int33 converter among NUM_REQ requesters.
// A shadow pipeline carries id/tag beside each op; results land in a credit-protected FIFO.
module fp_to_int_share_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned LATENCY    = 3,
  parameter int unsigned TAG_W      = 8,
  parameter int unsigned RESP_DEPTH = 5
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*32-1:0]      req_a,
  input  logic [NUM_REQ*TAG_W-1:0]   req_tag,
  output logic [31:0]                cvt_a,
  input  logic [32:0]                cvt_q,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [32:0]                resp_q,
  output logic [$clog2(NUM_REQ)-1:0] resp_id,
  output logic [TAG_W-1:0]           resp_tag,
  output logic                       busy
);

  localparam int unsigned ID_W    = $clog2(NUM_REQ);
  localparam int unsigned STAGES  = LATENCY + 1;
  localparam int unsigned CNT_W   = $clog2(LATENCY + RESP_DEPTH + 2) + 1;
  localparam int unsigned PTR_W   = $clog2(RESP_DEPTH);
  localparam int unsigned ENTRY_W = 33 + ID_W + TAG_W;

  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [31:0]        cvt_a_q, cvt_a_d;
  logic [STAGES-1:0]  shd_vld_q;
  logic [ID_W-1:0]    shd_id_q  [STAGES];
  logic [TAG_W-1:0]   shd_tag_q [STAGES];

  logic [ENTRY_W-1:0] fifo_mem [RESP_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   fifo_cnt_q, fifo_cnt_d;

  logic [CNT_W-1:0]   inflight;
  logic [ID_W:0]      arb_sum;
  logic [ID_W-1:0]    gnt_idx;
  logic               gnt_any;
  logic               issue_ok;
  logic               grant_vld;
  logic               push, pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      inflight = inflight + CNT_W'(shd_vld_q[i]);
    end
  end

  // First valid index at or after ptr_q, wrapping.
  always_comb begin
    arb_sum = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      arb_sum = {1'b0, ptr_q} + (ID_W + 1)'(k);
      if (arb_sum >= (ID_W + 1)'(NUM_REQ)) begin
        arb_sum = arb_sum - (ID_W + 1)'(NUM_REQ);
      end
      if (!gnt_any && req_valid[arb_sum[ID_W-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = arb_sum[ID_W-1:0];
      end
    end
  end

  // A pop in this cycle deliberately earns no credit until the next cycle.
  assign issue_ok  = reset_n && ((inflight + fifo_cnt_q) < CNT_W'(RESP_DEPTH));
  assign grant_vld = gnt_any && issue_ok;

  always_comb begin
    req_ready          = '0;
    req_ready[gnt_idx] = grant_vld;
  end

  always_comb begin
    ptr_d   = ptr_q;
    cvt_a_d = cvt_a_q;
    if (grant_vld) begin
      ptr_d   = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
      cvt_a_d = req_a[32*gnt_idx +: 32];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q     <= '0;
      cvt_a_q   <= '0;
      shd_vld_q <= '0;
      for (int unsigned i = 0; i < STAGES; i++) begin
        shd_id_q[i]  <= '0;
        shd_tag_q[i] <= '0;
      end
    end else begin
      ptr_q        <= ptr_d;
      cvt_a_q      <= cvt_a_d;
      shd_vld_q    <= {shd_vld_q[STAGES-2:0], grant_vld};
      shd_id_q[0]  <= gnt_idx;
      shd_tag_q[0] <= req_tag[TAG_W*gnt_idx +: TAG_W];
      for (int unsigned i = 1; i < STAGES; i++) begin
        shd_id_q[i]  <= shd_id_q[i-1];
        shd_tag_q[i] <= shd_tag_q[i-1];
      end
    end
  end

  assign cvt_a = cvt_a_q;

  assign push       = shd_vld_q[LATENCY];
  assign resp_valid = (fifo_cnt_q != '0);
  assign pop        = resp_valid && resp_ready;

  always_comb begin
    fifo_cnt_d = fifo_cnt_q;
    unique case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      fifo_cnt_q <= fifo_cnt_d;
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
    end
  end

  // Storage needs no reset: the count alone decides what is valid.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= {cvt_q, shd_id_q[LATENCY], shd_tag_q[LATENCY]};
    end
  end

  assign {resp_q, resp_id, resp_tag} = fifo_mem[rd_ptr_q];

  assign busy = (inflight != '0) || (fifo_cnt_q != '0);

endmodule
